hazard_flush_ctrl: RTL and testbench
====================================

# hazard_flush_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline with interrupts and exceptions. Each cycle it decides whether the F/D registers hold and whether a bubble goes into E. It tracks multiply/divide occupancy with a countdown. On an exception or interrupt it issues the global flush to the D/E/M/W pipeline registers and steers the PC. It sits beside the datapath; all of its outputs drive pipeline-register enables and clears plus the PC mux.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu issue
- DIV_CYC, 10, busy cycles after a div/divu issue

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rs_D  in  5  rs of the instruction in D
- rt_D  in  5  rt of the instruction in D
- tuse_rs_D  in  2  cycles until D needs rs (3 = not used)
- tuse_rt_D  in  2  cycles until D needs rt (3 = not used)
- a3_E  in  5  destination register of E
- tnew_E  in  2  cycles until E's result is ready
- a3_M  in  5  destination register of M
- tnew_M  in  2  cycles until M's result is ready
- md_start_E  in  1  mult/div instruction is in E this cycle
- md_is_div_E  in  1  1 = div type, 0 = mult type
- md_use_D  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo
- exc_req_M  in  1  exception or interrupt taken at M
- eret_D  in  1  eret in D
- stall_F  out  1  hold PC
- stall_D  out  1  hold the D register
- flush_E  out  1  load a bubble into E
- exc_flush  out  1  clear D/E/M/W (drives EXC_flush)
- pc_sel  out  2  0 = sequential/branch, 1 = handler 0x4180, 2 = EPC
- md_busy  out  1  HI/LO unit busy

## Operation
Data hazard:
- stall_rs = (rs_D≠0) & ((rs_D==a3_E & tuse_rs_D<tnew_E) | (rs_D==a3_M & tuse_rs_D<tnew_M)).
- stall_rt is the same expression using rt_D and tuse_rt_D.

Mult/div hazard:
- stall_md = md_use_D & (md_busy | md_start_E).

Stall request:
- stall = stall_rs | stall_rt | stall_md.
- When stall is asserted: stall_F = stall_D = flush_E = 1.

Countdown register cnt (4 bits):
- Load: on a rising edge with md_start_E=1, exc_flush=0 and cnt=0, cnt loads MULT_CYC or DIV_CYC according to md_is_div_E.
- Decrement: otherwise, when cnt≠0, cnt decrements by 1.
- md_busy = (cnt≠0).
- An exception does not clear a countdown already in progress; the operation completes.
- A start that coincides with exc_flush is discarded, because its E instruction is being killed.
- md_start_E while cnt≠0 cannot occur because stall_md prevents it. The block ignores it.

State machine (RUN, EXC):
- RUN: if exc_req_M=1, then exc_flush=1 and pc_sel=1 in the same cycle, and the next state is EXC.
- EXC (one cycle): exc_flush=0 and exc_req_M is ignored (M holds a bubble). Return to RUN.

Priority:
- exc_flush forces stall_F = stall_D = flush_E = 0 and overrides eret.

eret:
- If eret_D=1 with no exception and no stall, pc_sel=2.
- If a stall is active, pc_sel=0 and eret re-evaluates next cycle.

## Timing
- Reset values: cnt=0, state=RUN; every output is 0 in the cycle after reset and stays 0 while reset is high.
- All hazard outputs and exc_flush are combinational from current inputs and state. Consumers act on the next clk edge.
- md_busy rises one cycle after a mult/div is in E and stays high for exactly MULT_CYC or DIV_CYC cycles.
- Exception latency: exc_req_M at cycle t → exc_flush at t → D/E/M/W cleared and PC = 0x4180 at edge t+1.
- Reset mid-countdown: cnt goes to 0 at the next edge.
- Reset has priority over exc_req_M.

## Test plan
- RAW load-use: a3_E=8, tnew_E=2, rs_D=8, tuse_rs_D=1 → stall_F=stall_D=flush_E=1. With rs_D=0 → all 0.
- M-stage hazard: a3_M=9, tnew_M=1, rt_D=9, tuse_rt_D=0 → stall. With tuse_rt_D=1 → no stall.
- Mult busy: md_start_E with md_is_div_E=0 at cycle 0 → md_busy=1 for cycles 1–5. An mflo in D stalls during cycles 0–5 and releases at cycle 6. A div gives 10 busy cycles.
- Exception with a concurrent stall: exc_req_M=1 while a hazard is present → exc_flush=1, pc_sel=1, all stall outputs 0. In the next cycle exc_req_M=1 is ignored (EXC state).
- Exception vs. md start: md_start_E and exc_req_M in the same cycle → md_busy stays 0. A divide already counting continues through the flush.
- eret: eret_D=1 → pc_sel=2. eret_D with a concurrent exc_req_M → pc_sel=1. Reset mid-divide (cnt=6) → md_busy=0 next cycle.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: stall/flush sequencer for the five-stage pipeline with mult/div occupancy and exception flush
module hazard_flush_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_E,
  input  logic [1:0] tnew_E,
  input  logic [4:0] a3_M,
  input  logic [1:0] tnew_M,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  input  logic       md_use_D,
  input  logic       exc_req_M,
  input  logic       eret_D,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_E,
  output logic       exc_flush,
  output logic [1:0] pc_sel,
  output logic       md_busy
);
  localparam logic       RUN = 1'b0;
  localparam logic       EXC = 1'b1;
  localparam logic [3:0] MC  = MULT_CYC[3:0];
  localparam logic [3:0] DC  = DIV_CYC[3:0];
  logic       state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stall_rs, stall_rt, stall_md, stall;
  always_comb begin
    stall_rs  = (rs_D != 5'd0) & ((rs_D == a3_E & tuse_rs_D < tnew_E) | (rs_D == a3_M & tuse_rs_D < tnew_M));
    stall_rt  = (rt_D != 5'd0) & ((rt_D == a3_E & tuse_rt_D < tnew_E) | (rt_D == a3_M & tuse_rt_D < tnew_M));
    md_busy   = ~reset & (cnt_q != 4'd0);
    stall_md  = md_use_D & (md_busy | md_start_E);
    stall     = ~reset & (stall_rs | stall_rt | stall_md);
    exc_flush = ~reset & (state_q == RUN) & exc_req_M;
    stall_F   = stall & ~exc_flush;
    stall_D   = stall_F;
    flush_E   = stall_F;
    pc_sel    = exc_flush ? 2'd1 : (~reset & eret_D & ~stall) ? 2'd2 : 2'd0;
    state_d   = (~reset & exc_flush) ? EXC : RUN;
    // a start killed by the flush never loads; a running count always completes
    cnt_d     = reset ? 4'd0
              : (md_start_E & ~exc_flush & cnt_q == 4'd0) ? (md_is_div_E ? DC : MC)
              : (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: directed vectors with hand-computed expectations for hazard_flush_ctrl
module tb_hazard_flush_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_E, a3_M;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic       md_start_E, md_is_div_E, md_use_D, exc_req_M, eret_D;
  logic       stall_F, stall_D, flush_E, exc_flush, md_busy;
  logic [1:0] pc_sel;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_flush_ctrl dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_E(a3_E), .tnew_E(tnew_E), .a3_M(a3_M), .tnew_M(tnew_M), .md_start_E(md_start_E),
    .md_is_div_E(md_is_div_E), .md_use_D(md_use_D), .exc_req_M(exc_req_M), .eret_D(eret_D),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E), .exc_flush(exc_flush),
    .pc_sel(pc_sel), .md_busy(md_busy)
  );
  wire [6:0] outs = {stall_F, stall_D, flush_E, exc_flush, pc_sel, md_busy};
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic idle();
    rs_D = 0; rt_D = 0; a3_E = 0; a3_M = 0;
    tuse_rs_D = 3; tuse_rt_D = 3; tnew_E = 0; tnew_M = 0;
    md_start_E = 0; md_is_div_E = 0; md_use_D = 0; exc_req_M = 0; eret_D = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    reset = 1;
    a3_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1; exc_req_M = 1; eret_D = 1;
    step();
    chk("reset_hold", outs, 7'b0000000);
    idle();
    reset = 0;
    step();
    chk("after_reset", outs, 7'b0000000);
    a3_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1; #1;
    chk("raw_E_rs", outs, 7'b1110000);
    rs_D = 0; a3_E = 0; #1;
    chk("raw_r0", outs, 7'b0000000);
    tnew_E = 2; tuse_rs_D = 2; rs_D = 8; a3_E = 8; #1;
    chk("raw_E_equal", outs, 7'b0000000);
    idle();
    a3_M = 9; tnew_M = 1; rt_D = 9; tuse_rt_D = 0; #1;
    chk("raw_M_rt", outs, 7'b1110000);
    tuse_rt_D = 1; #1;
    chk("raw_M_ok", outs, 7'b0000000);
    idle();
    md_start_E = 1; md_use_D = 1; #1;
    chk("mult_c0", outs, 7'b1110000);
    step();
    md_start_E = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("mult_c%0d", i), outs, 7'b1110001);
      step();
    end
    chk("mult_c6", outs, 7'b0000000);
    idle();
    md_start_E = 1; md_is_div_E = 1;
    step();
    idle();
    for (int i = 1; i <= 11; i++) begin
      chk($sformatf("div_c%0d", i), outs, {6'b0, i <= 10});
      step();
    end
    a3_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1; exc_req_M = 1; #1;
    chk("exc_stall", outs, 7'b0001010);
    step();
    chk("exc_ignored", outs, 7'b1110000);
    step();
    chk("exc_again", outs, 7'b0001010);
    idle();
    step();
    chk("exc_clear", outs, 7'b0000000);
    md_start_E = 1; exc_req_M = 1; #1;
    chk("exc_md_start", outs, 7'b0001010);
    step();
    idle();
    #1;
    chk("md_killed", outs, 7'b0000000);
    step();
    md_start_E = 1; md_is_div_E = 1;
    step();
    idle();
    for (int i = 1; i <= 11; i++) begin
      exc_req_M = (i == 3);
      #1;
      chk($sformatf("div_exc_c%0d", i), outs, {3'b0, i == 3, i == 3 ? 2'd1 : 2'd0, i <= 10});
      step();
    end
    idle();
    eret_D = 1; #1;
    chk("eret", outs, 7'b0000100);
    exc_req_M = 1; #1;
    chk("eret_exc", outs, 7'b0001010);
    step();
    exc_req_M = 0; #1;
    chk("eret_in_exc", outs, 7'b0000100);
    a3_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1; #1;
    chk("eret_stall", outs, 7'b1110000);
    idle();
    step();
    md_start_E = 1; md_is_div_E = 1;
    step();
    idle();
    for (int i = 1; i < 5; i++) step();
    chk("div_cnt6_busy", outs, 7'b0000001);
    reset = 1; #1;
    chk("reset_mid_div", outs, 7'b0000000);
    step();
    reset = 0; #1;
    chk("after_reset_div", outs, 7'b0000000);
    step();
    chk("still_idle", outs, 7'b0000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
